// File: rtl/force_acc_ctrl.sv
// rtl/force_acc_ctrl.sv - sequencer for the 1-cycle SP accumulator, one summed force per particle
// Operand mux is combinational so the accumulator feedback loop closes in a single cycle.
module force_acc_ctrl #(
   parameter int DATA_WIDTH  = 32,
   parameter int ID_WIDTH    = 9,
   parameter int COUNT_WIDTH = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   input  logic [ID_WIDTH-1:0]    in_id,
   input  logic [DATA_WIDTH-1:0]  in_data,
   input  logic                   in_last,
   output logic                   acc_ena,
   output logic                   acc_clr,
   output logic [DATA_WIDTH-1:0]  acc_ax,
   output logic [DATA_WIDTH-1:0]  acc_ay,
   input  logic [DATA_WIDTH-1:0]  acc_result,
   output logic                   out_valid,
   output logic [ID_WIDTH-1:0]    out_id,
   output logic [DATA_WIDTH-1:0]  out_data,
   output logic [COUNT_WIDTH-1:0] out_count
);

   typedef enum logic {IDLE, ACCUM} state_t;

   state_t                 state;
   logic [ID_WIDTH-1:0]    cur_id;
   logic [COUNT_WIDTH-1:0] cnt;
   logic                   flush_pend;

   logic beat;
   logic id_change;
   logic id_close;
   logic start_beat;

   // A beat in the flush cycle always opens a fresh particle, even with the same ID.
   always_comb begin
      beat       = in_valid && !rst;
      id_change  = (in_id != cur_id);
      id_close   = beat && (state == ACCUM) && !flush_pend && id_change;
      start_beat = beat && ((state == IDLE) || flush_pend || id_change);
      acc_ena    = beat;
      acc_clr    = rst;
      acc_ax     = in_data;
      acc_ay     = start_beat ? '0 : acc_result;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         cur_id     <= '0;
         cnt        <= '0;
         flush_pend <= 1'b0;
         out_valid  <= 1'b0;
         out_id     <= '0;
         out_data   <= '0;
         out_count  <= '0;
      end else begin
         out_valid <= 1'b0;
         // acc_result still holds the old sum on an ID change, and includes the last beat on a flush.
         if (flush_pend || id_close) begin
            out_valid <= 1'b1;
            out_id    <= cur_id;
            out_data  <= acc_result;
            out_count <= cnt;
         end
         flush_pend <= beat && in_last;
         if (beat) begin
            state <= ACCUM;
            if (start_beat) begin
               cur_id <= in_id;
               cnt    <= COUNT_WIDTH'(1);
            end else if (cnt != '1) begin
               cnt <= cnt + 1'b1;
            end
         end else if (flush_pend) begin
            state <= IDLE;
         end
      end
   end

endmodule

// File: tb/tb_force_acc_ctrl.sv
// tb/tb_force_acc_ctrl.sv - directed and random bench for force_acc_ctrl
// Two instances (8-bit and 2-bit counters) share stimulus; each drives its own accumulator model.
module tb_force_acc_ctrl;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic [8:0]  in_id;
   logic [31:0] in_data;
   logic        in_last;

   logic        acc_ena0, acc_clr0, out_valid0;
   logic [31:0] acc_ax0, acc_ay0, acc_r0, out_data0;
   logic [8:0]  out_id0;
   logic [7:0]  out_count0;

   logic        acc_ena1, acc_clr1, out_valid1;
   logic [31:0] acc_ax1, acc_ay1, acc_r1, out_data1;
   logic [8:0]  out_id1;
   logic [1:0]  out_count1;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   typedef struct {
      logic [8:0]  id;
      logic [31:0] data;
      int          cnt;
      int          due;
   } exp_t;

   exp_t        q[$];
   logic [31:0] log_data[$];
   int          log_c0[$];
   int          log_c1[$];

   bit          m_open = 0;
   logic [8:0]  m_id   = '0;
   real         m_sum  = 0.0;
   int          m_cnt  = 0;

   force_acc_ctrl u_dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_id(in_id), .in_data(in_data),
      .in_last(in_last), .acc_ena(acc_ena0), .acc_clr(acc_clr0), .acc_ax(acc_ax0),
      .acc_ay(acc_ay0), .acc_result(acc_r0), .out_valid(out_valid0), .out_id(out_id0),
      .out_data(out_data0), .out_count(out_count0)
   );

   force_acc_ctrl #(.COUNT_WIDTH(2)) u_sat (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_id(in_id), .in_data(in_data),
      .in_last(in_last), .acc_ena(acc_ena1), .acc_clr(acc_clr1), .acc_ax(acc_ax1),
      .acc_ay(acc_ay1), .acc_result(acc_r1), .out_valid(out_valid1), .out_id(out_id1),
      .out_data(out_data1), .out_count(out_count1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] real_to_sp(input real r);
      logic [63:0] b;
      logic [7:0]  e;
      if (r == 0.0) return 32'h0;
      b = $realtobits(r);
      e = 8'(int'(b[62:52]) - 1023 + 127);
      return {b[63], e, b[51:29]};
   endfunction

   function automatic real sp_to_real(input logic [31:0] s);
      logic [10:0] e;
      if (s[30:0] == 31'h0) return 0.0;
      e = 11'(int'(s[30:23]) - 127 + 1023);
      return $bitstoreal({s[31], e, s[22:0], 29'h0});
   endfunction

   // Behavioural single-precision accumulator with a registered result.
   always @(posedge clk) begin
      if (acc_clr0)      acc_r0 <= 32'h0;
      else if (acc_ena0) acc_r0 <= real_to_sp(sp_to_real(acc_ax0) + sp_to_real(acc_ay0));
      if (acc_clr1)      acc_r1 <= 32'h0;
      else if (acc_ena1) acc_r1 <= real_to_sp(sp_to_real(acc_ax1) + sp_to_real(acc_ay1));
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Called at a falling edge: check registered outputs, drive a beat, update the model, advance.
   task automatic step(input bit v, input logic [8:0] id, input logic [31:0] d,
                       input bit l, input bit r);
      bit   exp_v;
      bit   start;
      exp_t e;
      while (q.size() > 0 && q[0].due < cyc) void'(q.pop_front());
      exp_v = (q.size() > 0 && q[0].due == cyc);
      chk("out_valid", 64'(out_valid0), 64'(exp_v));
      chk("out_valid_sat", 64'(out_valid1), 64'(exp_v));
      if (exp_v) begin
         e = q.pop_front();
         chk("out_id", 64'(out_id0), 64'(e.id));
         chk("out_data", 64'(out_data0), 64'(e.data));
         chk("out_count", 64'(out_count0), 64'((e.cnt > 255) ? 255 : e.cnt));
         chk("out_id_sat", 64'(out_id1), 64'(e.id));
         chk("out_data_sat", 64'(out_data1), 64'(e.data));
         chk("out_count_sat", 64'(out_count1), 64'((e.cnt > 3) ? 3 : e.cnt));
         log_data.push_back(out_data0);
         log_c0.push_back(int'(out_count0));
         log_c1.push_back(int'(out_count1));
      end

      in_valid = v; in_id = id; in_data = d; in_last = l; rst = r;
      #1;
      chk("acc_ena", 64'(acc_ena0), 64'(v && !r));
      chk("acc_clr", 64'(acc_clr0), 64'(r));
      chk("acc_ax", 64'(acc_ax0), 64'(d));
      start = !m_open || (id != m_id);
      if (v && !r) begin
         chk("acc_ay", 64'(acc_ay0), start ? 64'h0 : 64'(acc_r0));
         chk("acc_ay_sat", 64'(acc_ay1), start ? 64'h0 : 64'(acc_r1));
      end

      if (r) begin
         m_open = 0;
      end else if (v) begin
         if (m_open && id != m_id) begin
            q.push_back('{m_id, real_to_sp(m_sum), m_cnt, cyc + 1});
            m_open = 0;
         end
         if (!m_open) begin
            m_open = 1; m_id = id; m_sum = sp_to_real(d); m_cnt = 1;
         end else begin
            m_sum = m_sum + sp_to_real(d); m_cnt++;
         end
         if (l) begin
            q.push_back('{m_id, real_to_sp(m_sum), m_cnt, cyc + 2});
            m_open = 0;
         end
      end

      @(posedge clk);
      cyc++;
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 9'd0, 32'h0, 0, 0);
   endtask

   initial begin
      in_valid = 1; in_id = 9'd0; in_data = 32'h3F800000; in_last = 0; rst = 1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_out_valid", 64'(out_valid0), 64'h0);
      chk("rst_out_id", 64'(out_id0), 64'h0);
      chk("rst_out_data", 64'(out_data0), 64'h0);
      chk("rst_out_count", 64'(out_count0), 64'h0);
      chk("rst_acc_clr", 64'(acc_clr0), 64'h1);
      chk("rst_acc_ena", 64'(acc_ena0), 64'h0);
      cyc = 0;

      // single particle
      step(1, 9'd5, 32'h3F800000, 0, 0);
      step(1, 9'd5, 32'h40000000, 0, 0);
      step(1, 9'd5, 32'h40400000, 1, 0);
      idle(3);
      // ID change with last on the new particle
      step(1, 9'd1, 32'h3F800000, 0, 0);
      step(1, 9'd1, 32'h3F800000, 0, 0);
      step(1, 9'd2, 32'h40800000, 1, 0);
      idle(3);
      // gap inside a particle
      step(1, 9'd7, 32'h3F000000, 0, 0);
      idle(3);
      step(1, 9'd7, 32'h3F000000, 1, 0);
      idle(3);
      // restart in the flush cycle with the same ID
      step(1, 9'd3, 32'h40000000, 1, 0);
      step(1, 9'd3, 32'h3F800000, 1, 0);
      idle(3);
      // reset mid-particle, with a beat presented during reset
      step(1, 9'd4, 32'h3F800000, 0, 0);
      step(1, 9'd4, 32'h3F800000, 0, 0);
      step(1, 9'd4, 32'h3F800000, 0, 1);
      step(1, 9'd4, 32'h3F800000, 1, 0);
      idle(3);
      // five beats: saturates the 2-bit counter
      for (int i = 0; i < 5; i++) step(1, 9'd6, 32'h3F800000, (i == 4), 0);
      idle(3);
      // 260 beats: saturates the 8-bit counter
      for (int i = 0; i < 260; i++) step(1, 9'd9, 32'h3E800000, (i == 259), 0);
      idle(3);

      chk("log_size", 64'(log_data.size()), 64'd9);
      if (log_data.size() == 9) begin
         chk("t1_data", 64'(log_data[0]), 64'h40C00000);
         chk("t1_count", 64'(log_c0[0]), 64'd3);
         chk("t2a_data", 64'(log_data[1]), 64'h40000000);
         chk("t2a_count", 64'(log_c0[1]), 64'd2);
         chk("t2b_data", 64'(log_data[2]), 64'h40800000);
         chk("t2b_count", 64'(log_c0[2]), 64'd1);
         chk("t3_data", 64'(log_data[3]), 64'h3F800000);
         chk("t3_count", 64'(log_c0[3]), 64'd2);
         chk("t4a_data", 64'(log_data[4]), 64'h40000000);
         chk("t4b_data", 64'(log_data[5]), 64'h3F800000);
         chk("t5_data", 64'(log_data[6]), 64'h3F800000);
         chk("t5_count", 64'(log_c0[6]), 64'd1);
         chk("t6_data", 64'(log_data[7]), 64'h40A00000);
         chk("t6_count", 64'(log_c0[7]), 64'd5);
         chk("t6_count_sat", 64'(log_c1[7]), 64'd3);
         chk("t7_data", 64'(log_data[8]), 64'h42820000);
         chk("t7_count", 64'(log_c0[8]), 64'd255);
      end

      for (int i = 0; i < 600; i++) begin
         bit          v;
         bit          l;
         logic [8:0]  id;
         int          k;
         v  = ($urandom % 4) != 0;
         l  = ($urandom % 6) == 0;
         id = 9'($urandom_range(0, 3));
         k  = int'($urandom_range(0, 16)) - 8;
         step(v, id, real_to_sp(k * 0.25), l, 0);
      end
      step(1, 9'd0, 32'h3F800000, 1, 0);
      idle(4);
      chk("queue_drained", 64'(q.size()), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
